my_arb4way16: RTL and testbench

- Round-robin arbiter that shares one 16-bit datapath (a 4-way 16-bit mux plus a one-entry output register) between four requesters a, b, c and d.
- Each cycle it picks at most one requester, drives the mux select, captures the selected word and presents it on a valid/ready output port.
- Sits between multiple 16-bit producers and a single downstream consumer. Sustains one transfer per cycle when the consumer is always ready.

---
 rtl/my_arb4way16_if.sv | 34 +++
 rtl/my_arb4way16.sv | 140 ++++++++++++++
 tb/tb_my_arb4way16.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/my_arb4way16_if.sv
// my_arb4way16_if: request/data/grant bundle for the 4-way 16-bit arbiter.
// master = producers+consumer side, slave = arbiter side; lock exists only with ARB_LOCK_EN.
interface my_arb4way16_if;
  logic [3:0]  req;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [15:0] d;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef ARB_LOCK_EN
  logic        lock;
`endif

  modport master (
    output req, a, b, c, d, out_ready,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  gnt, sel, out, out_valid, busy
  );

  modport slave (
    input  req, a, b, c, d, out_ready,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output gnt, sel, out, out_valid, busy
  );
endinterface

// File: rtl/my_arb4way16.sv
// my_arb4way16: round-robin 4:1 arbiter over a shared 16-bit mux + one-entry out reg.
// Ports: clk, rst_n (sync, active low), bus (my_arb4way16_if.slave); macro ARB_LOCK_EN adds lock.
module my_arb4way16 #(
  parameter int unsigned RST_PTR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  my_arb4way16_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ost_t;

  localparam logic [1:0] RP = 2'(RST_PTR);

  ost_t        st_q, st_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  last_sel_q, last_sel_d;
  logic [15:0] out_q, out_d;

  logic        take;
  logic        win;
  logic [1:0]  w;
  logic [3:0]  elig;
  logic [15:0] mux_w;
  logic        out_valid_w;

`ifdef ARB_LOCK_EN
  logic        lock_own_q, lock_own_d;
  logic [1:0]  owner_q, owner_d;
`endif

  assign out_valid_w = (st_q == FULL);
  assign take        = !out_valid_w || bus.out_ready;

`ifdef ARB_LOCK_EN
  // while locked, only the owner may compete
  assign elig = lock_own_q ? (bus.req & (4'b0001 << owner_q))
                           : bus.req;
`else
  assign elig = bus.req;
`endif

  // first set bit scanning up from ptr, wrapping 3->0
  always_comb begin
    win = 1'b0;
    w   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!win && elig[ptr_q + 2'(k)]) begin
        win = 1'b1;
        w   = ptr_q + 2'(k);
      end
    end
    if (!rst_n || !take) begin
      win = 1'b0;
    end
  end

  always_comb begin
    mux_w = bus.a;
    case (w)
      2'd0: mux_w = bus.a;
      2'd1: mux_w = bus.b;
      2'd2: mux_w = bus.c;
      2'd3: mux_w = bus.d;
      default: mux_w = bus.a;
    endcase
  end

  assign bus.gnt       = win ? (4'b0001 << w) : 4'b0000;
  assign bus.sel       = win ? w : last_sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_w;
  assign bus.busy      = out_valid_w || (bus.req != 4'b0000);

  always_comb begin
    st_d       = st_q;
    out_d      = out_q;
    ptr_d      = ptr_q;
    last_sel_d = last_sel_q;
`ifdef ARB_LOCK_EN
    lock_own_d = lock_own_q;
    owner_d    = owner_q;
`endif
    if (win) begin
      st_d       = FULL;
      out_d      = mux_w;
      last_sel_d = w;
      ptr_d      = w + 2'd1;
`ifdef ARB_LOCK_EN
      if (lock_own_q) begin
        if (bus.lock) begin
          ptr_d = ptr_q;
        end else begin
          lock_own_d = 1'b0;
          ptr_d      = owner_q + 2'd1;
        end
      end else if (bus.lock) begin
        lock_own_d = 1'b1;
        owner_d    = w;
        ptr_d      = ptr_q;
      end
`endif
    end else if (out_valid_w && bus.out_ready) begin
      st_d = EMPTY;
    end
`ifdef ARB_LOCK_EN
    // owner walked away: drop the lock (no win is possible here)
    if (lock_own_q && take && !bus.req[owner_q]) begin
      lock_own_d = 1'b0;
      ptr_d      = owner_q + 2'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= EMPTY;
      out_q      <= 16'h0000;
      ptr_q      <= RP;
      last_sel_q <= RP;
`ifdef ARB_LOCK_EN
      lock_own_q <= 1'b0;
      owner_q    <= 2'd0;
`endif
    end else begin
      st_q       <= st_d;
      out_q      <= out_d;
      ptr_q      <= ptr_d;
      last_sel_q <= last_sel_d;
`ifdef ARB_LOCK_EN
      lock_own_q <= lock_own_d;
      owner_q    <= owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_my_arb4way16.sv
// tb_my_arb4way16: directed + random stimulus against a behavioural arbiter model.
// Ports of the DUT are driven through my_arb4way16_if.
module tb_my_arb4way16;
  localparam int unsigned RST_PTR = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  my_arb4way16_if ifc ();

  my_arb4way16 #(.RST_PTR(RST_PTR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int n_chk = 0;
  int n_err = 0;

  int          m_ptr;
  int          m_last;
  logic [15:0] m_out;
  bit          m_val;
  bit          m_known;
  bit          e_win;
  int          e_w;
  logic [3:0]  e_gnt;
  int          wt[4];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dat(input int i);
    case (i)
      0: return ifc.a;
      1: return ifc.b;
      2: return ifc.c;
      default: return ifc.d;
    endcase
  endfunction

  task automatic setd(input int i, input logic [15:0] v);
    case (i)
      0: ifc.a = v;
      1: ifc.b = v;
      2: ifc.c = v;
      default: ifc.d = v;
    endcase
  endtask

  task automatic drv(input logic rn, input logic [3:0] r, input logic rdy);
    rst_n         = rn;
    ifc.req       = r;
    ifc.out_ready = rdy;
  endtask

  // called at a negedge with inputs applied; returns at the next negedge
  task automatic cyc(input string tag);
    bit take;
    take  = !m_val || ifc.out_ready;
    e_win = 1'b0;
    e_w   = 0;
    if (rst_n && m_known && take) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (!e_win && ifc.req[i]) begin
          e_win = 1'b1;
          e_w   = i;
        end
      end
    end
    e_gnt = e_win ? 4'(1 << e_w) : 4'b0000;
    #1;
    chk({tag, ".gnt"}, 32'(ifc.gnt), 32'(e_gnt));
    if (m_known) begin
      chk({tag, ".sel"}, 32'(ifc.sel), e_win ? e_w : m_last);
      chk({tag, ".out"}, 32'(ifc.out), 32'(m_out));
      chk({tag, ".vld"}, 32'(ifc.out_valid), 32'(m_val));
      chk({tag, ".busy"}, 32'(ifc.busy),
          32'(m_val || (ifc.req != 4'b0000)));
    end
    if (rst_n && m_known) begin
      for (int i = 0; i < 4; i++) begin
        if (ifc.gnt[i]) begin
          chk({tag, ".fair"}, 32'(wt[i] <= 3), 32'd1);
          wt[i] = 0;
        end else if (ifc.req[i] && ifc.gnt != 4'b0000) begin
          wt[i]++;
        end else if (!ifc.req[i]) begin
          wt[i] = 0;
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_ptr   = int'(RST_PTR);
      m_last  = int'(RST_PTR);
      m_out   = 16'h0000;
      m_val   = 1'b0;
      m_known = 1'b1;
      for (int i = 0; i < 4; i++) wt[i] = 0;
    end else if (e_win) begin
      m_out  = dat(e_w);
      m_val  = 1'b1;
      m_ptr  = (e_w + 1) % 4;
      m_last = e_w;
    end else if (ifc.out_ready && m_val) begin
      m_val = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] r;
    m_known = 1'b0;
    m_val   = 1'b0;
    m_out   = 16'h0000;
    m_ptr   = 0;
    m_last  = 0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    drv(1'b0, 4'h0, 1'b1);
`ifdef ARB_LOCK_EN
    ifc.lock = 1'b0;
`endif
    ifc.a = 16'h5555;
    ifc.b = 16'hAAAA;
    ifc.c = 16'h00FF;
    ifc.d = 16'hFF00;
    @(negedge clk);

    drv(1'b0, 4'hF, 1'b1);
    cyc("rst");
    cyc("rst");

    drv(1'b1, 4'hF, 1'b1);
    repeat (5) cyc("rr");
    drv(1'b1, 4'h0, 1'b1);
    cyc("drain");

    drv(1'b1, 4'b0100, 1'b0);
    cyc("bp");
    drv(1'b1, 4'b0000, 1'b0);
    cyc("bp");
    cyc("bp");
    drv(1'b1, 4'b1000, 1'b0);
    cyc("bp");
    cyc("bp");
    drv(1'b1, 4'b1000, 1'b1);
    cyc("bp");
    drv(1'b1, 4'b0000, 1'b1);
    cyc("bp");

    drv(1'b1, 4'b0110, 1'b1);
    cyc("wrap");
    drv(1'b1, 4'b0100, 1'b1);
    cyc("wrap");
    drv(1'b1, 4'b0000, 1'b1);
    cyc("wrap");
    cyc("wrap");

    drv(1'b1, 4'b0010, 1'b0);
    cyc("mrst");
    drv(1'b1, 4'b0000, 1'b0);
    cyc("mrst");
    drv(1'b0, 4'b0000, 1'b0);
    cyc("mrst");
    drv(1'b1, 4'b0000, 1'b0);
    cyc("mrst");

    for (int n = 0; n < 3000; n++) begin
      r = ifc.req;
      for (int i = 0; i < 4; i++) begin
        if (r[i]) begin
          if (e_gnt[i]) begin
            setd(i, 16'($urandom));
            if ($urandom_range(1) == 0) r[i] = 1'b0;
          end
        end else if ($urandom_range(9) < 4) begin
          r[i] = 1'b1;
          setd(i, 16'($urandom));
        end
      end
      drv(1'($urandom_range(299) != 0), r,
          1'($urandom_range(3) != 0));
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
